tx_rate_arb: RTL and testbench

- Parametrised successor to the single-stream rate-buffer path in the TX datapath.
- Accepts frame-slot requests (length plus stream id) from STR_NUM per-stream rate generators.
- Arbitrates them round-robin into one synchronous rate FIFO.
- Serves tx_gen with the established level-request / level-valid read handshake, with pause gating, test flush and drop accounting.
- Sits between the bw_con/ir_con rate generators and tx_gen, in a single clock domain.

---
 rtl/tx_rate_defs_pkg.sv | 36 +++
 rtl/tx_rate_fifo.sv | 84 ++++++++
 rtl/tx_rate_arb.sv | 239 +++++++++++++++++++++++
 tb/tb_tx_rate_arb.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_rate_defs_pkg.sv
// ---------------------------------------------------------------------------
// tx_rate_defs_pkg
//   Shared constants and helpers for the multi-stream TX rate arbiter.
//   - clog2 / sid_w : width derivation for stream ids and FIFO pointers
//   - entry layout  : {sid, len}, sid in the MSBs, len in the LSBs
//   - default parameter values for STR_NUM, LEN_W, DEPTH and CNT_W
// ---------------------------------------------------------------------------
package tx_rate_defs_pkg;

  localparam int DEF_STR_NUM = 8;
  localparam int DEF_LEN_W   = 14;
  localparam int DEF_DEPTH   = 512;
  localparam int DEF_CNT_W   = 16;

  // Entry field positions: length field starts at bit 0, sid sits above it.
  localparam int LEN_LSB = 0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Stream-id width; never narrower than one bit.
  function automatic int sid_w(input int str_num);
    return (str_num > 1) ? clog2(str_num) : 1;
  endfunction

  function automatic int sid_lsb(input int len_w);
    return LEN_LSB + len_w;
  endfunction

endpackage

// File: rtl/tx_rate_fifo.sv
// ---------------------------------------------------------------------------
// tx_rate_fifo
//   Single-clock RAM FIFO with registered read data, registered full/empty
//   flags and occupancy count, and a synchronous flush.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   flush           empties the FIFO on the next edge (overrides push/pop)
//   push, push_data write request and data (caller guarantees !full)
//   pop             read request (caller guarantees !empty)
//   pop_data        registered head entry, updated on the pop edge
//   full, empty     registered status flags
//   count           registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module tx_rate_fifo
  import tx_rate_defs_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int CNT_BITS = ADDR_W + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    pop_data,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [CNT_BITS-1:0] count_next;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are ADDR_W wide, so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      pop_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      count <= count_next;
      full  <= (count_next == CNT_BITS'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/tx_rate_arb.sv
// ---------------------------------------------------------------------------
// tx_rate_arb
//   Collects frame-slot requests from STR_NUM rate generators into one
//   holding register per stream, arbitrates them round-robin into a rate
//   FIFO and serves tx_gen through the level-request / level-valid read
//   handshake. Grants are gated by test_en, FIFO full and pause.
//   Optional build macro TX_RATE_PRIO_EN: stream 0 gets strict priority over
//   the round-robin streams (round-robin pointer untouched by its grants).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   test_en       test-running level; falling edge flushes, rising clears drops
//   pause_en      enables response to pause_on
//   pause_on      pause-frame active level
//   str_wr        per-stream slot request pulses
//   str_len       per-stream lengths, stream i at [i*LEN_W +: LEN_W]
//   rd_rqst       read request level from tx_gen
//   rd_vald       read data valid level
//   rd_data       {sid, len} of the popped entry
//   fifo_full     FIFO full (registered)
//   fifo_empty    FIFO empty (registered)
//   fill_cnt      FIFO occupancy
//   drop_cnt      saturating count of requests lost to a busy holding register
// ---------------------------------------------------------------------------
module tx_rate_arb
  import tx_rate_defs_pkg::*;
#(
  parameter int STR_NUM = DEF_STR_NUM,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int SID_W  = sid_w(STR_NUM),
  localparam int FILL_W = clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     test_en,
  input  logic                     pause_en,
  input  logic                     pause_on,
  input  logic [STR_NUM-1:0]       str_wr,
  input  logic [STR_NUM*LEN_W-1:0] str_len,
  input  logic                     rd_rqst,
  output logic                     rd_vald,
  output logic [SID_W+LEN_W-1:0]   rd_data,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [FILL_W-1:0]        fill_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int ENT_W = SID_W + LEN_W;

  logic                   test_en_q;
  logic                   test_fall;
  logic                   test_rise;

  logic [LEN_W-1:0]       len_in   [STR_NUM];
  logic [STR_NUM-1:0]     hold_vld;
  logic [LEN_W-1:0]       hold_len [STR_NUM];

  logic [SID_W-1:0]       rr_ptr;
  logic                   grant_en;
  logic                   grant;
  logic [SID_W-1:0]       gnt_idx;
  logic                   upd_ptr;
  logic [STR_NUM-1:0]     gnt_oh;
  int                     cand;
  logic [ENT_W-1:0]       push_data;

  logic [STR_NUM-1:0]     drop_vec;
  logic [CNT_W:0]         drop_sum;
  logic [CNT_W-1:0]       drop_cnt_next;

  logic                   served;
  logic                   pop;

  // -------------------------------------------------------------------------
  // test_en edge detect: flush on the fall, drop counter clear on the rise
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      test_en_q <= 1'b0;
    end else begin
      test_en_q <= test_en;
    end
  end

  assign test_fall = test_en_q && !test_en;
  assign test_rise = !test_en_q && test_en;

  // -------------------------------------------------------------------------
  // Per-stream unpacking and drop detection
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < STR_NUM; gi++) begin : g_stream
      assign len_in[gi]   = str_len[gi*LEN_W +: LEN_W];
      // A request is lost only if the slot is still occupied after this edge.
      assign drop_vec[gi] = str_wr[gi] && hold_vld[gi] && !gnt_oh[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Holding registers. A grant in the same cycle frees the slot, so a new
  // request arriving alongside its grant is captured rather than dropped.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld <= '0;
      for (int i = 0; i < STR_NUM; i++) begin
        hold_len[i] <= '0;
      end
    end else if (test_fall) begin
      hold_vld <= '0;
      for (int i = 0; i < STR_NUM; i++) begin
        hold_len[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STR_NUM; i++) begin
        if (str_wr[i] && (!hold_vld[i] || gnt_oh[i])) begin
          hold_vld[i] <= 1'b1;
          hold_len[i] <= len_in[i];
        end else if (gnt_oh[i]) begin
          hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Arbiter: first pending stream after rr_ptr, searched cyclically.
  // test_en is low during a flush cycle, so a grant never coincides with it.
  // -------------------------------------------------------------------------
  assign grant_en = test_en && !fifo_full && !(pause_en && pause_on);

  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    upd_ptr = 1'b0;
    cand    = 0;
    if (grant_en) begin
`ifdef TX_RATE_PRIO_EN
      // Stream 0 wins outright and leaves the rotation where it was.
      if (hold_vld[0]) begin
        grant = 1'b1;
      end
`endif
      for (int k = 1; k <= STR_NUM; k++) begin
        cand = (int'(rr_ptr) + k) % STR_NUM;
        if (!grant && hold_vld[cand]) begin
          grant   = 1'b1;
          gnt_idx = SID_W'(cand);
          upd_ptr = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (grant) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    push_data = '0;
    push_data[sid_lsb(LEN_W) +: SID_W] = gnt_idx;
    push_data[LEN_LSB +: LEN_W]        = hold_len[gnt_idx];
  end

  // Reset value STR_NUM-1 makes stream 0 the first candidate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= SID_W'(STR_NUM - 1);
    end else if (test_fall) begin
      rr_ptr <= SID_W'(STR_NUM - 1);
    end else if (upd_ptr) begin
      rr_ptr <= gnt_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Drop counter: several streams may drop in one cycle; saturates at '1.
  // -------------------------------------------------------------------------
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < STR_NUM; i++) begin
      drop_sum = drop_sum + {{CNT_W{1'b0}}, drop_vec[i]};
    end
    drop_cnt_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (test_rise) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read handshake: one pop per rd_rqst assertion. served blocks further
  // pops until rd_rqst drops; rd_data only moves on a pop, so it is stable
  // for as long as rd_vald is high.
  // -------------------------------------------------------------------------
  assign pop = rd_rqst && !fifo_empty && !served && !test_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      served  <= 1'b0;
      rd_vald <= 1'b0;
    end else if (test_fall || !rd_rqst) begin
      served  <= 1'b0;
      rd_vald <= 1'b0;
    end else if (pop) begin
      served  <= 1'b1;
      rd_vald <= 1'b1;
    end
  end

  tx_rate_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (test_fall),
    .push      (grant),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_cnt)
  );

endmodule

// File: tb/tb_tx_rate_arb.sv
// ---------------------------------------------------------------------------
// tb_tx_rate_arb
//   Directed scoreboard bench for tx_rate_arb (default parameters).
//   Stimulus pushes the expected {sid, len} entries in FIFO order; the
//   monitor pops and compares each time rd_vald rises.
//   Honours TX_RATE_PRIO_EN for the priority scenario.
// ---------------------------------------------------------------------------
module tb_tx_rate_arb;

  localparam int STR_NUM = 8;
  localparam int LEN_W   = 14;
  localparam int DEPTH   = 512;
  localparam int CNT_W   = 16;
  localparam int SID_W   = 3;
  localparam int FILL_W  = 10;
  localparam int DW      = SID_W + LEN_W;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     test_en = 1'b0;
  logic                     pause_en = 1'b0;
  logic                     pause_on = 1'b0;
  logic [STR_NUM-1:0]       str_wr = '0;
  logic [STR_NUM*LEN_W-1:0] str_len = '0;
  logic                     rd_rqst = 1'b0;
  logic                     rd_vald;
  logic [DW-1:0]            rd_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FILL_W-1:0]        fill_cnt;
  logic [CNT_W-1:0]         drop_cnt;

  int            total = 0;
  int            bad = 0;
  int            n_reads = 0;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] exp_ent;
  logic [DW-1:0] last_data = '0;
  logic          vald_prev = 1'b0;

  always #5 clk = ~clk;

  tx_rate_arb #(
    .STR_NUM (STR_NUM),
    .LEN_W   (LEN_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .test_en    (test_en),
    .pause_en   (pause_en),
    .pause_on   (pause_on),
    .str_wr     (str_wr),
    .str_len    (str_len),
    .rd_rqst    (rd_rqst),
    .rd_vald    (rd_vald),
    .rd_data    (rd_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fill_cnt   (fill_cnt),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ent(input int sid, input int len);
    return {SID_W'(sid), LEN_W'(len)};
  endfunction

  task automatic set_len(input int s, input int v);
    str_len[s*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_one();
    int n;
    n = 0;
    rd_rqst = 1'b1;
    while (!rd_vald && n < 1000) begin
      tick();
      n++;
    end
    if (!rd_vald) begin
      total++;
      bad++;
      $display("FAIL read_timeout: got rd_vald=0 expected 1 within 1000 cycles");
    end
    rd_rqst = 1'b0;
    tick();
  endtask

  // Monitor: compare each newly presented entry, and hold-stability while valid.
  always @(negedge clk) begin
    if (rd_vald && !vald_prev) begin
      n_reads++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_data: got 0x%0h expected no entry", rd_data);
      end else begin
        exp_ent = sb_q.pop_front();
        $display("read %0d: sid=%0d len=0x%0h", n_reads, rd_data[DW-1 -: SID_W], rd_data[LEN_W-1:0]);
        check("rd_data", 32'(rd_data), 32'(exp_ent));
      end
    end else if (rd_vald && vald_prev) begin
      check("rd_data_stable", 32'(rd_data), 32'(last_data));
    end
    last_data = rd_data;
    vald_prev = rd_vald;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) tick();
    check("reset_fill", 32'(fill_cnt), 0);
    check("reset_empty", 32'(fifo_empty), 1);
    check("reset_full", 32'(fifo_full), 0);
    check("reset_vald", 32'(rd_vald), 0);
    check("reset_drop", 32'(drop_cnt), 0);
    check("reset_data", 32'(rd_data), 0);
    reset_n = 1'b1;
    tick();
    test_en = 1'b1;
    tick();
    tick();

    // ---------------- 1: single slot and handshake ----------------
    str_wr = 8'h04;
    set_len(2, 'h5EE);
    sb_q.push_back(ent(2, 'h5EE));
    tick();
    str_wr = '0;
    check("t1_fill_before_grant", 32'(fill_cnt), 0);
    tick();
    check("t1_fill", 32'(fill_cnt), 1);
    rd_rqst = 1'b1;
    tick();
    check("t1_vald", 32'(rd_vald), 1);
    check("t1_data", 32'(rd_data), 32'(ent(2, 'h5EE)));
    tick();
    tick();
    check("t1_vald_held", 32'(rd_vald), 1);
    check("t1_fill_after_pop", 32'(fill_cnt), 0);
    rd_rqst = 1'b0;
    check("t1_vald_at_fall", 32'(rd_vald), 1);
    tick();
    check("t1_vald_cleared", 32'(rd_vald), 0);

    // restart the rotation from stream 0
    test_en = 1'b0;
    tick();
    test_en = 1'b1;
    tick();

    // ---------------- 2: all streams, round-robin order and wrap ----------------
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < STR_NUM; i++) begin
        set_len(i, 64 + i + 8 * b);
        sb_q.push_back(ent(i, 64 + i + 8 * b));
      end
      str_wr = '1;
      tick();
      str_wr = '0;
      repeat (8) tick();
      check("t2_fill_batch", 32'(fill_cnt), 32'(8 * (b + 1)));
    end
    // push and pop on the same edge
    str_wr = 8'h10;
    set_len(4, 'h444);
    sb_q.push_back(ent(4, 'h444));
    tick();
    str_wr = '0;
    rd_rqst = 1'b1;
    tick();
    check("t2_fill_push_pop", 32'(fill_cnt), 16);
    check("t2_vald_push_pop", 32'(rd_vald), 1);
    rd_rqst = 1'b0;
    tick();
    repeat (16) read_one();
    check("t2_fill_drained", 32'(fill_cnt), 0);
    check("t2_drop", 32'(drop_cnt), 0);

    // ---------------- 3: pause backpressure and drop ----------------
    pause_en = 1'b1;
    pause_on = 1'b1;
    str_wr = 8'h08;
    set_len(3, 'h33);
    sb_q.push_back(ent(3, 'h33));
    tick();
    str_wr = '0;
    tick();
    str_wr = 8'h08;
    set_len(3, 'h44);
    tick();
    str_wr = '0;
    tick();
    tick();
    check("t3_fill_paused", 32'(fill_cnt), 0);
    check("t3_drop", 32'(drop_cnt), 1);
    pause_on = 1'b0;
    tick();
    check("t3_fill_released", 32'(fill_cnt), 1);
    read_one();
    pause_en = 1'b0;

    // ---------------- 4: full FIFO ----------------
    for (int k = 0; k < DEPTH + 2; k++) begin
      str_wr = 8'h02;
      set_len(1, k);
      if (k <= DEPTH) sb_q.push_back(ent(1, k));
      tick();
    end
    str_wr = '0;
    tick();
    check("t4_fill_full", 32'(fill_cnt), DEPTH);
    check("t4_full", 32'(fifo_full), 1);
    check("t4_empty", 32'(fifo_empty), 0);
    check("t4_drop", 32'(drop_cnt), 2);
    read_one();
    check("t4_refill", 32'(fill_cnt), DEPTH);
    check("t4_full_again", 32'(fifo_full), 1);
    tick();
    tick();
    check("t4_fill_steady", 32'(fill_cnt), DEPTH);
    test_en = 1'b0;
    tick();
    check("t4_flush_fill", 32'(fill_cnt), 0);
    check("t4_flush_empty", 32'(fifo_empty), 1);
    check("t4_flush_full", 32'(fifo_full), 0);
    check("t4_drop_kept", 32'(drop_cnt), 2);
    sb_q.delete();
    test_en = 1'b1;
    tick();
    check("t4_drop_cleared", 32'(drop_cnt), 0);

    // ---------------- 5: flush with read outstanding ----------------
    for (int k = 0; k < 10; k++) begin
      str_wr = 8'h40;
      set_len(6, 'h200 + k);
      sb_q.push_back(ent(6, 'h200 + k));
      tick();
    end
    str_wr = '0;
    tick();
    tick();
    check("t5_fill", 32'(fill_cnt), 10);
    rd_rqst = 1'b1;
    tick();
    check("t5_vald", 32'(rd_vald), 1);
    check("t5_fill_after_pop", 32'(fill_cnt), 9);
    test_en = 1'b0;
    tick();
    check("t5_flush_fill", 32'(fill_cnt), 0);
    check("t5_flush_vald", 32'(rd_vald), 0);
    check("t5_flush_empty", 32'(fifo_empty), 1);
    sb_q.delete();
    rd_rqst = 1'b0;
    test_en = 1'b1;
    tick();

    // ---------------- 6: streams 0 and 5 continuously pending ----------------
    set_len(0, 'h100);
    set_len(5, 'h500);
`ifdef TX_RATE_PRIO_EN
    for (int i = 0; i < 5; i++) sb_q.push_back(ent(0, 'h100));
    sb_q.push_back(ent(5, 'h500));
`else
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(ent(0, 'h100));
      sb_q.push_back(ent(5, 'h500));
    end
`endif
    str_wr = 8'h21;
    repeat (5) tick();
    str_wr = '0;
    repeat (4) tick();
    check("t6_fill", 32'(fill_cnt), 6);
    check("t6_drop", 32'(drop_cnt), 4);
    repeat (6) read_one();
    check("t6_fill_drained", 32'(fill_cnt), 0);
    check("t6_sb_drained", 32'(sb_q.size()), 0);

    // ---------------- reset mid-operation ----------------
    str_wr = 8'h04;
    set_len(2, 'h11);
    tick();
    str_wr = '0;
    tick();
    str_wr = 8'h08;
    set_len(3, 'h22);
    tick();
    str_wr = '0;
    check("rst_fill_before", 32'(fill_cnt), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_fill_async", 32'(fill_cnt), 0);
    check("rst_empty_async", 32'(fifo_empty), 1);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("rst_no_stale_hold", 32'(fill_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
